operand_pair_stager: RTL
========================

Name: operand_pair_stager

Overview:
Buffered upstream stage for the 8-bit adder datapath. It accepts 16-bit words over a valid/ready handshake and holds them in a small FIFO. It presents each word as an (a, b) operand pair using one of two fixed mappings: a byte split, or a zero-extended low nibble paired with a constant. It also counts delivered pairs so the consumer side can be checked against the producer side.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2
CONST_B, 8'h55, value driven on out_b in nibble mode
CNT_W, 16, width of the delivered-pair counter

Ports:
clk  input  1  rising-edge clock for all state
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept a word this cycle
in_data  input  16  upstream word
in_mode  input  1  0 = byte split, 1 = nibble mode; captured with the word
out_valid  output  1  operand pair valid
out_ready  input  1  adder side accepts the pair
out_a  output  8  operand a
out_b  output  8  operand b
out_count  output  CNT_W  number of pairs delivered since reset
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO pointers and occupancy cleared.
  - out_valid=0, out_a=0, out_b=0, out_count=0, full=0, empty=1, in_ready=0.
  - in_ready goes to 1 on the first cycle after reset deasserts.
- Reset asserted mid-operation discards all buffered words at that edge. No partial transfer completes in that cycle.
- Push: in_valid & in_ready at a clk edge. The stage stores {in_mode, in_data} at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: out_valid & out_ready at a clk edge. The read pointer increments modulo DEPTH, and out_count increments by 1, wrapping from 2^CNT_W-1 to 0.
- Handshake rules:
  - in_ready = !full. It is registered-state derived only and never depends on out_ready.
  - out_valid = !empty.
  - out_a and out_b are stable while out_valid=1 and out_ready=0.
- Occupancy tracking:
  - Push without pop: +1.
  - Pop without push: -1.
  - Push and pop together: unchanged, and both pointers advance.
  - Full: a push is impossible (in_ready=0); a pop in that cycle frees one entry, and in_ready=1 on the next cycle.
  - Empty: a pop is impossible (out_valid=0); a push makes the word visible on the next cycle.
- Latency: a word pushed at edge N is presented on out_a/out_b with out_valid=1 after edge N, provided it is at the head of the FIFO. There is no bypass, so the minimum latency is 1 cycle.
- Operand mapping from the head entry (combinational from FIFO storage):
  - mode 0: out_a = data[15:8], out_b = data[7:0].
  - mode 1: out_a = {4'h0, data[3:0]}, out_b = CONST_B. data[15:4] is ignored.
  - When empty, out_a and out_b are driven 0.
- Mode is per word. Mixed-mode sequences are delivered in order, each with its own mapping.
- full and empty are exact occupancy flags: occupancy == DEPTH and occupancy == 0 respectively.
- No overflow or underflow is possible by construction. An in_valid held high while full is not a push. in_data may change freely while in_ready=0.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release. Required: out_valid=0, out_a=out_b=0, out_count=0, empty=1, full=0; in_ready=0 during reset and 1 on the first cycle after.
- Byte split: push 16'hA53C mode 0 with out_ready=1. Required: one cycle later out_a=8'hA5, out_b=8'h3C, out_valid=1; after the pop, out_count=1 and empty=1.
- Nibble mode: push 16'hFFF7 mode 1. Required: out_a=8'h07, out_b=8'h55; with CONST_B overridden to 8'h0F, out_b=8'h0F.
- Backpressure/full:
  - Stimulus: out_ready=0, push 16'h0102 then 16'h0304 with DEPTH=2, then a third word 16'h0506 held on in_valid.
  - Required: full=1, in_ready=0, third word not accepted, out_a=8'h01 and out_b=8'h02 held stable for 5 cycles.
  - Then raise out_ready: pairs (01,02), (03,04), (05,06) are delivered in order, and out_count=3.
- Simultaneous push/pop:
  - Stimulus: with one entry buffered, drive in_valid=1 and out_ready=1 continuously for 10 words 16'h0000..16'h0009 alternating modes.
  - Required: occupancy stays 1, one pair per cycle in order, correct per-word mapping, out_count=10.
- Reset mid-stream and counter wrap:
  - Stimulus: with 2 entries buffered, assert rst_n=0 for 1 cycle.
  - Required: empty=1, out_count=0, and the buffered words are never delivered.
  - Then with CNT_W=4, deliver 17 pairs. Required: out_count=1.

Source files
------------

// File: rtl/operand_pair_stager.sv
// ============================================================================
//  Module      : operand_pair_stager
//  Description : Buffered upstream stage for the 8-bit adder datapath. Accepts
//                16-bit words with a per-word mode bit over valid/ready, holds
//                them in a small FIFO, and presents the head entry as an
//                (a, b) operand pair. Counts delivered pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_pair_stager #(
  parameter int         DEPTH   = 2,
  parameter logic [7:0] CONST_B = 8'h55,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_a,
  output logic [7:0]       out_b,
  output logic [CNT_W-1:0] out_count,
  output logic             full,
  output logic             empty
);

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = DEPTH[AW:0];

  // Each entry carries the mode bit alongside the word: {mode, data}.
  logic [16:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Low throughout reset, high from the first cycle after; keeps in_ready
  // deasserted while the stage is held in reset.
  logic             ready_q;

  logic             w_push;
  logic             w_pop;
  logic [16:0]      w_head;

  assign full      = (occ_q == DEPTH_OCC);
  assign empty     = (occ_q == '0);
  assign in_ready  = ready_q & ~full;
  assign out_valid = ~empty;
  assign out_count = count_q;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  assign w_head = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and delivered-pair counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q + CNT_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      ready_q  <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      mem_q[wr_ptr_q] <= {in_mode, in_data};
    end
  end

  // Operand mapping from the head entry; zeros when nothing is buffered.
  always_comb begin
    out_a = 8'h00;
    out_b = 8'h00;
    if (!empty) begin
      if (w_head[16]) begin
        out_a = {4'h0, w_head[3:0]};
        out_b = CONST_B;
      end else begin
        out_a = w_head[15:8];
        out_b = w_head[7:0];
      end
    end
  end

endmodule

`default_nettype wire
